// File: rtl/seq_mul_radix4_su.sv
// Iterative radix-4 multiplier, unsigned/signed operand modes, exact 2*WIDTH-bit product.
// Latency: WIDTH/2 cycles from accept edge to out_valid; one result per WIDTH/2+1 cycles streaming.
// Backpressure: result held in DONE until out_ready; new operands accepted only in IDLE or on the DONE handshake.
module seq_mul_radix4_su #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [1:0]           out_mode
);

  localparam int N  = WIDTH / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]      r_mode;
  logic [PW-1:0]   r_acc;
  logic [KW-1:0]   r_k;
  logic            r_out_valid;

  logic [1:0]      w_mode_n;
  logic            w_accept;
  logic            w_a_signed;
  logic            w_last;
  logic            w_neg_digit;
  logic [1:0]      w_digit;
  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_a_x2;
  logic [PW-1:0]   w_p0;
  logic [PW-1:0]   w_p1;
  logic [PW-1:0]   w_term;

  // Mode 11 is an alias of unsigned x unsigned and is stored/reported as 00.
  assign w_mode_n = (in_mode == 2'b11) ? 2'b00 : in_mode;

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_a_signed = (r_mode == 2'b01) || (r_mode == 2'b10);
  assign w_last     = (r_k == KW'(N - 1));
  // Top digit of a signed b carries weight -2 on its upper bit.
  assign w_neg_digit = w_last && (r_mode == 2'b10);
  assign w_digit     = 2'(r_b >> {r_k, 1'b0});

  assign w_a_ext = w_a_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_a_x2  = {w_a_ext[PW-2:0], 1'b0};

  // Digit product built from the two digit bits: d0*a + d1*(+/-2a).
  assign w_p0   = w_digit[0] ? w_a_ext : '0;
  assign w_p1   = w_digit[1] ? (w_neg_digit ? ('0 - w_a_x2) : w_a_x2) : '0;
  assign w_term = (w_p0 + w_p1) << {r_k, 1'b0};

  assign out_valid   = r_out_valid;
  assign out_product = r_acc;
  assign out_mode    = r_mode;

  // Control FSM and datapath: latch on accept, accumulate one digit per BUSY cycle, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 2'b00;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= BUSY;
      r_a         <= in_a;
      r_b         <= in_b;
      r_mode      <= w_mode_n;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        BUSY: begin
          r_acc <= r_acc + w_term;
          r_k   <= r_k + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_radix4_su.sv
// Bench for seq_mul_radix4_su: WIDTH=8 directed/random streams and WIDTH=4 exhaustive sweep.
// Expected products come from a plain integer a*b reference, queued at accept, popped at handshake.
// Outputs sampled at negedge or #1 after posedge; every wait is bounded.
module tb_seq_mul_radix4_su;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // WIDTH=8 instance
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  in_a8 = '0;
  logic [7:0]  in_b8 = '0;
  logic [1:0]  in_mode8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [15:0] out_product8;
  logic [1:0]  out_mode8;

  // WIDTH=4 instance
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  in_a4 = '0;
  logic [3:0]  in_b4 = '0;
  logic [1:0]  in_mode4 = '0;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [7:0]  out_product4;
  logic [1:0]  out_mode4;

  seq_mul_radix4_su #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_product(out_product8), .out_mode(out_mode8)
  );

  seq_mul_radix4_su #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_mode(in_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_product(out_product4), .out_mode(out_mode4)
  );

  logic [17:0] sb8[$];
  logic [9:0]  sb4[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers per mode and multiply.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] m);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if ((m == 2'b01 || m == 2'b10) && a[w-1]) sa = sa - (longint'(1) << w);
    if (m == 2'b10 && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Scoreboard pops on handshake, checked at negedge while inputs are stable.
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) chk("sb8_unexpected", 1, 0);
      else begin
        logic [17:0] e;
        e = sb8.pop_front();
        chk("prod8", 64'(out_product8), 64'(e[15:0]));
        chk("mode8", 64'(out_mode8), 64'(e[17:16]));
      end
    end
    if (!rst && out_valid4 && out_ready4) begin
      if (sb4.size() == 0) chk("sb4_unexpected", 1, 0);
      else begin
        logic [9:0] e;
        e = sb4.pop_front();
        chk("prod4", 64'(out_product4), 64'(e[7:0]));
        chk("mode4", 64'(out_mode4), 64'(e[9:8]));
      end
    end
  end

  int last_acc8 = 0;

  // Present an op, wait (bounded) for ready, push expectation, return #1 after the accept edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int n;
    logic [1:0] mn;
    n = 0;
    mn = (m == 2'b11) ? 2'b00 : m;
    in_a8 = a; in_b8 = b; in_mode8 = m; in_valid8 = 1'b1;
    #1;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready8) chk("send8_timeout", 1, 0);
    else begin
      sb8.push_back({mn, ref_mul(8, 32'(a), 32'(b), m)[15:0]});
      @(posedge clk); #1;
      last_acc8 = cyc;
    end
    in_valid8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    int n;
    logic [63:0] r;
    n = 0;
    in_a4 = a; in_b4 = b; in_mode4 = m; in_valid4 = 1'b1;
    #1;
    while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready4) chk("send4_timeout", 1, 0);
    else begin
      r = ref_mul(4, 32'(a), 32'(b), m);
      sb4.push_back({m, r[7:0]});
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb8.size() != 0 || sb4.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    chk(tag, 64'(sb8.size() + sb4.size()), 0);
  endtask

  initial begin
    int lat;
    int prev;
    // Reset state
    #1;
    chk("rst_valid8", 64'(out_valid8), 0);
    chk("rst_ready8", 64'(in_ready8), 1);
    chk("rst_prod8", 64'(out_product8), 0);
    chk("rst_mode8", 64'(out_mode8), 0);
    chk("rst_valid4", 64'(out_valid4), 0);
    chk("rst_prod4", 64'(out_product4), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: s x u, -128 * 255, latency 4
    out_ready8 = 1'b1;
    send8(8'h80, 8'hFF, 2'b01);
    chk("t1_busy_in_ready", 64'(in_ready8), 0);
    chk("t1_busy_out_valid", 64'(out_valid8), 0);
    lat = 0;
    while (!out_valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("t1_latency", 64'(lat), 4);
    chk("t1_const", 64'(out_product8), 64'h8080);
    @(posedge clk); #1;
    chk("t1_idle_valid", 64'(out_valid8), 0);

    // 2: s x s, u x u, mode 11 alias, back to back
    send8(8'h80, 8'h80, 2'b10);
    send8(8'hFF, 8'hFF, 2'b00);
    send8(8'hFF, 8'hFF, 2'b11);
    send8(8'h7F, 8'h81, 2'b10);
    send8(8'hFF, 8'h01, 2'b01);
    drain("t2_drain");

    // 3: consumer stalls 10 cycles; result must hold, new ops ignored
    out_ready8 = 1'b0;
    send8(8'h12, 8'hC4, 2'b10);
    lat = 0;
    while (!out_valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
    in_a8 = 8'h55; in_b8 = 8'h33; in_mode8 = 2'b00; in_valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t3_valid", 64'(out_valid8), 1);
      chk("t3_prod", 64'(out_product8), ref_mul(8, 32'h12, 32'hC4, 2'b10));
      chk("t3_mode", 64'(out_mode8), 2);
      chk("t3_in_ready", 64'(in_ready8), 0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    drain("t3_drain");

    // 4: reset mid-operation discards it
    send8(8'h55, 8'h66, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    void'(sb8.pop_back());
    chk("t4_valid", 64'(out_valid8), 0);
    chk("t4_prod", 64'(out_product8), 0);
    chk("t4_mode", 64'(out_mode8), 0);
    chk("t4_in_ready", 64'(in_ready8), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t4_no_result", 64'(out_valid8), 0);
    end
    send8(8'hA5, 8'h3C, 2'b01);
    drain("t4_drain");

    // 5: continuous streaming, one accept every 5 cycles
    for (int i = 0; i < 20; i++) begin
      prev = last_acc8;
      send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      if (i > 0) chk("t5_interval", 64'(last_acc8 - prev), 5);
    end
    drain("t5_drain");

    // 6: WIDTH=4 exhaustive over three modes
    for (int m = 0; m < 3; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          send4(4'(a), 4'(b), 2'(m));
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
